multi_buffer_rr: RTL

MULTI_BUFFER_RR -- requirements
Module: multi_buffer_rr

---
 rtl/multi_buffer_rr.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/multi_buffer_rr.sv
// multi_buffer_rr: N_CH independent FIFOs drained round-robin into a single registered output stream.
// Build macro MULTI_BUFFER_ERRCODE_EN: overflows are also reported in-band as an ERR_CODE word.

module multi_buffer_rr #(
   parameter int unsigned     WDTH      = 32,
   parameter int unsigned     N_CH      = 4,
   parameter int unsigned     LOG_N_CH  = 2,
   parameter int unsigned     DEPTH     = 16,
   parameter int unsigned     LOG_DEPTH = 4,
   parameter logic [WDTH-1:0] ERR_CODE  = '1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [WDTH-1:0]     in_data,
   input  logic [LOG_N_CH-1:0] in_ch,
   input  logic                in_nd,
   input  logic                out_ready,
   output logic [WDTH-1:0]     out_data,
   output logic [LOG_N_CH-1:0] out_ch,
   output logic                out_nd,
   output logic [N_CH-1:0]     ch_full,
   output logic                write_error
);

   typedef logic [LOG_DEPTH:0]   cnt_t;
   typedef logic [LOG_DEPTH-1:0] ptr_t;
   typedef logic [LOG_N_CH-1:0]  ch_t;

   localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
   localparam ch_t  CH_LAST  = ch_t'(N_CH - 1);

   logic [WDTH-1:0] mem_q [N_CH][DEPTH];

   cnt_t cnt_q    [N_CH];
   cnt_t cnt_d    [N_CH];
   ptr_t wr_ptr_q [N_CH];
   ptr_t wr_ptr_d [N_CH];
   ptr_t rd_ptr_q [N_CH];
   ptr_t rd_ptr_d [N_CH];

   ch_t             last_q, last_d;
   logic [WDTH-1:0] out_data_d;
   ch_t             out_ch_d;
   logic            out_nd_d;
   logic            write_error_d;

   logic            wr_ok, wr_reject;
   logic            pick_found, pop_en;
   ch_t             pick_ch, cand;
   logic            err_emit;
   ch_t             err_ch;
   logic [N_CH-1:0] push_v, pop_v;

   always_comb begin
      for (int unsigned i = 0; i < N_CH; i++) begin
         ch_full[i] = (cnt_q[i] == CNT_FULL);
      end
   end

   // Fullness is judged on pre-edge counts, so a pop on the same edge never rescues a write.
   always_comb begin
      wr_reject = in_nd && ch_full[in_ch];
      wr_ok     = in_nd && !ch_full[in_ch];
   end

   always_comb begin
      pick_found = 1'b0;
      pick_ch    = '0;
      cand       = '0;
      for (int unsigned k = 1; k <= N_CH; k++) begin
         cand = last_q + ch_t'(k);
         if (!pick_found && (cnt_q[cand] != '0)) begin
            pick_found = 1'b1;
            pick_ch    = cand;
         end
      end
   end

`ifdef MULTI_BUFFER_ERRCODE_EN
   typedef enum logic {ERR_IDLE, ERR_PENDING} err_state_t;

   err_state_t err_state_q, err_state_d;
   ch_t        err_ch_q, err_ch_d;

   // An overflow arriving on the edge that emits the pending marker becomes the next pending one.
   always_comb begin
      err_emit    = (err_state_q == ERR_PENDING) && out_ready;
      err_ch      = err_ch_q;
      err_state_d = err_state_q;
      err_ch_d    = err_ch_q;
      if (err_emit) begin
         err_state_d = wr_reject ? ERR_PENDING : ERR_IDLE;
         err_ch_d    = in_ch;
      end else if (wr_reject && (err_state_q == ERR_IDLE)) begin
         err_state_d = ERR_PENDING;
         err_ch_d    = in_ch;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_state_q <= ERR_IDLE;
         err_ch_q    <= '0;
      end else begin
         err_state_q <= err_state_d;
         err_ch_q    <= err_ch_d;
      end
   end
`else
   always_comb begin
      err_emit = 1'b0;
      err_ch   = '0;
   end
`endif

   always_comb begin
      pop_en = out_ready && pick_found && !err_emit;
      push_v = '0;
      pop_v  = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         push_v[i]   = wr_ok && (in_ch == ch_t'(i));
         pop_v[i]    = pop_en && (pick_ch == ch_t'(i));
         cnt_d[i]    = cnt_q[i];
         if (push_v[i] && !pop_v[i]) begin
            cnt_d[i] = cnt_q[i] + cnt_t'(1);
         end else if (pop_v[i] && !push_v[i]) begin
            cnt_d[i] = cnt_q[i] - cnt_t'(1);
         end
         wr_ptr_d[i] = wr_ptr_q[i] + ptr_t'(push_v[i]);
         rd_ptr_d[i] = rd_ptr_q[i] + ptr_t'(pop_v[i]);
      end
   end

   always_comb begin
      out_data_d    = out_data;
      out_ch_d      = out_ch;
      out_nd_d      = 1'b0;
      last_d        = last_q;
      write_error_d = wr_reject;
      if (err_emit) begin
         out_data_d = ERR_CODE;
         out_ch_d   = err_ch;
         out_nd_d   = 1'b1;
      end else if (pop_en) begin
         out_data_d = mem_q[pick_ch][rd_ptr_q[pick_ch]];
         out_ch_d   = pick_ch;
         out_nd_d   = 1'b1;
         last_d     = pick_ch;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && wr_ok) begin
         mem_q[in_ch][wr_ptr_q[in_ch]] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            cnt_q[i]    <= '0;
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
         end
         last_q      <= CH_LAST;
         out_data    <= '0;
         out_ch      <= '0;
         out_nd      <= 1'b0;
         write_error <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            cnt_q[i]    <= cnt_d[i];
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
         end
         last_q      <= last_d;
         out_data    <= out_data_d;
         out_ch      <= out_ch_d;
         out_nd      <= out_nd_d;
         write_error <= write_error_d;
      end
   end

endmodule
